id_ex_ctrl_stage: RTL
=====================

// Module: id_ex_ctrl_stage
// PURPOSE
//  ID-stage main control decoder plus ID/EX pipeline register for the LEGv8 pipelined CPU.
//  - Decodes id_instr[31:21] into datapath control.
//  - Registers the control bits, ALUOp and opcode field into EX; ex_opcode[10:0] and ex_aluop feed ALU control directly.
//  - Supports stall (hold) and flush (bubble insert) from the hazard unit.
//  - Counts illegal opcodes.
// PARAMETERS
//  CNT_W           8  width of saturating illegal-instruction counter
//  NOP_ON_ILLEGAL  1  1: illegal opcode enters EX as bubble; 0: enters with all ctrl 0 but ex_valid=1
// PORTS
//  clk          in   1   clock, rising edge
//  reset        in   1   synchronous, active-high reset
//  id_instr     in   32  instruction in ID
//  id_valid     in   1   id_instr is a real instruction
//  stall        in   1   hold ID/EX contents
//  flush        in   1   replace ID/EX contents with bubble
//  id_reg2loc   out  1   combinational: regfile read-port-2 select (0=Rm[20:16], 1=Rt[4:0])
//  ex_opcode    out  11  registered instr[31:21]
//  ex_aluop     out  2   00 add (LDUR/STUR), 01 CBZ, 10 R-type
//  ex_alusrc    out  1   1 = immediate operand
//  ex_memread   out  1   load
//  ex_memwrite  out  1   store
//  ex_memtoreg  out  1   writeback from memory
//  ex_regwrite  out  1   writes Rd
//  ex_branch    out  1   CBZ
//  ex_uncond    out  1   B
//  ex_rd        out  5   instr[4:0]
//  ex_valid     out  1   EX slot holds a real instruction
//  ex_illegal   out  1   EX instruction had an unrecognised opcode
//  illegal_cnt  out  CNT_W  illegal opcodes accepted
// BEHAVIOUR
//  Decode, opcode = instr[31:21], x = don't-care bit:
//   ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000:
//    regwrite=1, aluop=10, all other ctrl=0
//   LDUR 11111000010: alusrc=1, memread=1, memtoreg=1, regwrite=1, aluop=00
//   STUR 11111000000: alusrc=1, memwrite=1, aluop=00, reg2loc=1
//   CBZ  10110100xxx: branch=1, aluop=01, reg2loc=1
//   B    000101xxxxx: uncond=1, aluop=00
//   Any other opcode: illegal; all ctrl=0, reg2loc=0
//  id_reg2loc: pure combinational from id_instr; independent of stall/flush/id_valid.
//  Register update priority, evaluated each clk edge:
//   1. reset
//   2. flush
//   3. stall
//   4. load
//  reset or flush:
//   - all ex_* outputs cleared to 0 (bubble: ex_valid=0, ctrl=0, ex_opcode=0, ex_rd=0).
//   - reset also sets illegal_cnt=0.
//  stall (and no flush): every ex_* holds; illegal_cnt holds.
//  load: ex_* <= decode(id_instr), ex_valid <= id_valid.
//   - id_valid=0 loads a bubble.
//   - Illegal with NOP_ON_ILLEGAL=1: ex_valid=0, ex_illegal=1.
//  Latency: exactly 1 cycle from ID to EX outputs; no combinational path id_* -> ex_*.
//  illegal_cnt: +1 on a load cycle with id_valid=1 and an illegal opcode; saturates at all-ones.
//   Not incremented on stall, flush or reset cycles.
//  flush and stall together: flush wins and a bubble is inserted.
//  Reset asserted mid-stream: takes effect on that edge regardless of stall/flush.
// TESTING
//  - reset=1 one cycle -> all ex_* = 0, illegal_cnt = 0.
//  - id_instr=0x8B030041 (ADD X1,X2,X3), id_valid=1 -> next cycle:
//    ex_opcode=0x458, ex_aluop=10, ex_regwrite=1, ex_rd=1, ex_valid=1; id_reg2loc=0 same cycle.
//  - 0xF84080C5 (LDUR X5,[X6,#8]) -> alusrc/memread/memtoreg/regwrite=1, aluop=00, rd=5.
//    Then stall=1 for 3 cycles while id_instr=0xB4000047 -> EX holds LDUR.
//    Release stall -> CBZ appears: branch=1, aluop=01.
//  - LDUR loaded, then stall=1 and flush=1 together -> bubble next cycle (ex_valid=0, all ctrl 0).
//  - id_instr=0x14000004 (B) -> ex_uncond=1, ex_regwrite=0.
//    id_instr=0xFFFFFFFF, id_valid=1 -> ex_illegal=1, ex_valid=0, illegal_cnt increments.
//  - CNT_W=2, 5 consecutive illegal loads -> illegal_cnt saturates at 3.
//    Illegal opcode with id_valid=0 -> no count.

Source files
------------

// File: rtl/id_ex_ctrl_if.sv
// ID/EX control bundle: ID-side inputs, decoded reg2loc, registered EX control.
// slave = the stage itself, master = whoever drives ID and consumes EX.
interface id_ex_ctrl_if #(
  parameter int CNT_W = 8
);
  logic [31:0]      id_instr;
  logic             id_valid;
  logic             stall;
  logic             flush;
  logic             id_reg2loc;
  logic [10:0]      ex_opcode;
  logic [1:0]       ex_aluop;
  logic             ex_alusrc;
  logic             ex_memread;
  logic             ex_memwrite;
  logic             ex_memtoreg;
  logic             ex_regwrite;
  logic             ex_branch;
  logic             ex_uncond;
  logic [4:0]       ex_rd;
  logic             ex_valid;
  logic             ex_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport slave (
    input  id_instr,
    input  id_valid,
    input  stall,
    input  flush,
    output id_reg2loc,
    output ex_opcode,
    output ex_aluop,
    output ex_alusrc,
    output ex_memread,
    output ex_memwrite,
    output ex_memtoreg,
    output ex_regwrite,
    output ex_branch,
    output ex_uncond,
    output ex_rd,
    output ex_valid,
    output ex_illegal,
    output illegal_cnt
  );

  modport master (
    output id_instr,
    output id_valid,
    output stall,
    output flush,
    input  id_reg2loc,
    input  ex_opcode,
    input  ex_aluop,
    input  ex_alusrc,
    input  ex_memread,
    input  ex_memwrite,
    input  ex_memtoreg,
    input  ex_regwrite,
    input  ex_branch,
    input  ex_uncond,
    input  ex_rd,
    input  ex_valid,
    input  ex_illegal,
    input  illegal_cnt
  );
endinterface

// File: rtl/id_ex_ctrl_stage.sv
// LEGv8 ID main control decoder + ID/EX register with stall/flush.
// Ports: clk, reset (sync, active-high), bus (id_ex_ctrl_if.slave).
module id_ex_ctrl_stage #(
  parameter int CNT_W          = 8,
  parameter bit NOP_ON_ILLEGAL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  id_ex_ctrl_if.slave  bus
);

  typedef struct packed {
    logic       alusrc;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
    logic       branch;
    logic       uncond;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [10:0] opcode;
    ctrl_t       ctrl;
    logic [4:0]  rd;
    logic        valid;
  } id_ex_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  logic [10:0] op;
  logic        is_rtype;
  logic        is_ldur;
  logic        is_stur;
  logic        is_cbz;
  logic        is_b;
  ctrl_t       dec;
  logic        reg2loc;
  id_ex_t      ld;
  id_ex_t      ex_d;
  id_ex_t      ex_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;
  logic        load_en;
  logic        unused_bits;

  assign op = bus.id_instr[31:21];
  assign unused_bits = ^bus.id_instr[20:5];

  assign is_rtype = (op == OP_ADD) || (op == OP_SUB)
                 || (op == OP_AND) || (op == OP_ORR);
  assign is_ldur  = (op == OP_LDUR);
  assign is_stur  = (op == OP_STUR);
  assign is_cbz   = (op[10:3] == 8'b10110100);
  assign is_b     = (op[10:5] == 6'b000101);

  always_comb begin
    dec     = '0;
    reg2loc = 1'b0;
    unique case (1'b1)
      is_rtype: begin
        dec.regwrite = 1'b1;
        dec.aluop    = 2'b10;
      end
      is_ldur: begin
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
        dec.regwrite = 1'b1;
      end
      is_stur: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        reg2loc      = 1'b1;
      end
      is_cbz: begin
        dec.branch   = 1'b1;
        dec.aluop    = 2'b01;
        reg2loc      = 1'b1;
      end
      is_b: begin
        dec.uncond   = 1'b1;
      end
      default: begin
        dec.illegal  = 1'b1;
      end
    endcase
  end

  // An invalid ID slot loads a full bubble, opcode and rd included.
  always_comb begin
    ld = '0;
    if (bus.id_valid) begin
      ld.opcode = op;
      ld.ctrl   = dec;
      ld.rd     = bus.id_instr[4:0];
      ld.valid  = !(dec.illegal && NOP_ON_ILLEGAL);
    end
  end

  assign load_en = !bus.flush && !bus.stall;

  always_comb begin
    ex_d = ex_q;
    if (bus.flush) begin
      ex_d = '0;
    end else if (!bus.stall) begin
      ex_d = ld;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_en && bus.id_valid && dec.illegal
        && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.id_reg2loc  = reg2loc;
  assign bus.ex_opcode   = ex_q.opcode;
  assign bus.ex_aluop    = ex_q.ctrl.aluop;
  assign bus.ex_alusrc   = ex_q.ctrl.alusrc;
  assign bus.ex_memread  = ex_q.ctrl.memread;
  assign bus.ex_memwrite = ex_q.ctrl.memwrite;
  assign bus.ex_memtoreg = ex_q.ctrl.memtoreg;
  assign bus.ex_regwrite = ex_q.ctrl.regwrite;
  assign bus.ex_branch   = ex_q.ctrl.branch;
  assign bus.ex_uncond   = ex_q.ctrl.uncond;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_illegal  = ex_q.ctrl.illegal;
  assign bus.illegal_cnt = cnt_q;

endmodule
